// File: rtl/sram_access_ctrl_if.sv
// sram_access_ctrl_if
//   Bundles the two buses around the 64-bit SRAM access controller:
//   - request/response side (64-bit word requests from the register buffer)
//   - SRAM side (32-bit strobes toward sram1024x32_wrapper and its status)
//   slave  : view used by the controller
//   master : view used by whatever drives requests and models the wrapper
interface sram_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [8:0]  req_idx;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  sram_state;

    modport slave (
        input  req_valid, req_write, req_idx, req_wdata, rdata, sram_state,
        output req_ready, resp_valid, resp_rdata, resp_err, addr, ren, wen, wdata
    );

    modport master (
        output req_valid, req_write, req_idx, req_wdata, rdata, sram_state,
        input  req_ready, resp_valid, resp_rdata, resp_err, addr, ren, wen, wdata
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl
//   Splits each 64-bit word request into two 32-bit SRAM accesses (low half
//   at {idx,0}, then high half at {idx,1}), follows the wrapper's sram_state
//   handshake, reassembles read data and reports errors / timeouts.
// Ports:
//   clk    : system clock
//   n_rst  : asynchronous active-low reset
//   bus    : sram_access_ctrl_if.slave (request/response + SRAM strobes)
//
// state  | meaning
// IDLE   | ready for a request (req_ready=1)
// LO_ACC | low-half strobe held until ACCESS / ERROR / timeout
// GAP    | one cycle with both strobes low between the two halves
// HI_ACC | high-half strobe held until ACCESS / ERROR / timeout
// RESP   | one-cycle resp_valid pulse
module sram_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic               clk,
    input  logic               n_rst,
    sram_access_ctrl_if.slave  bus
);

    localparam logic [1:0] SRAM_ACCESS = 2'b10;
    localparam logic [1:0] SRAM_ERROR  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LO_ACC = 3'd1,
        GAP    = 3'd2,
        HI_ACC = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_write;
    logic [8:0]       r_idx;
    logic [63:0]      r_wdata;
    logic [31:0]      r_rdata_lo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req_ready;
    logic [63:0]      r_resp_rdata;
    logic             r_resp_err;

    logic             w_accept;
    logic             w_in_acc;
    logic             w_access;
    logic             w_fail;
    logic             w_ren;
    logic             w_wen;
    logic [9:0]       w_addr;
    logic [31:0]      w_wdata;

    // req_ready is registered so it reads 0 while reset is asserted even
    // though the state register sits in IDLE.
    assign w_accept = (r_state == IDLE) && r_req_ready && bus.req_valid;
    assign w_in_acc = (r_state == LO_ACC) || (r_state == HI_ACC);
    assign w_access = w_in_acc && (bus.sram_state == SRAM_ACCESS);
    // The counter holds (cycles in state - 1), so CNT_LAST marks the
    // TIMEOUT_CYCLES-th strobe cycle without ACCESS.
    assign w_fail   = w_in_acc && !w_access &&
                      ((bus.sram_state == SRAM_ERROR) || (r_cnt == CNT_LAST));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ren   = 1'b0;
        w_wen   = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = LO_ACC;
            end
            LO_ACC: begin
                w_addr  = {r_idx, 1'b0};
                w_ren   = !r_write;
                w_wen   = r_write;
                w_wdata = r_write ? r_wdata[31:0] : 32'h0;
                if (w_fail)        w_next = RESP;
                else if (w_access) w_next = GAP;
            end
            GAP: begin
                w_next = HI_ACC;
            end
            HI_ACC: begin
                w_addr  = {r_idx, 1'b1};
                w_ren   = !r_write;
                w_wen   = r_write;
                w_wdata = r_write ? r_wdata[63:32] : 32'h0;
                if (w_fail || w_access) w_next = RESP;
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_write      <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_rdata_lo   <= '0;
            r_cnt        <= '0;
            r_req_ready  <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_req_ready <= (w_next == IDLE);
            if (w_accept) begin
                r_write <= bus.req_write;
                r_idx   <= bus.req_idx;
                r_wdata <= bus.req_wdata;
            end
            // Cleared outside the access states, so each half starts at 0.
            if (w_in_acc) r_cnt <= r_cnt + 1'b1;
            else          r_cnt <= '0;
            if (w_access && (r_state == LO_ACC) && !r_write) begin
                r_rdata_lo <= bus.rdata;
            end
            // resp_rdata only moves when a read completes both halves cleanly.
            if (w_access && (r_state == HI_ACC)) begin
                r_resp_err <= 1'b0;
                if (!r_write) r_resp_rdata <= {bus.rdata, r_rdata_lo};
            end else if (w_fail) begin
                r_resp_err <= 1'b1;
            end
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign bus.addr       = w_addr;
    assign bus.ren        = w_ren;
    assign bus.wen        = w_wen;
    assign bus.wdata      = w_wdata;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl
//   Drives 64-bit requests into sram_access_ctrl while playing the part of the
//   SRAM wrapper (latency N, injected ERROR, endless BUSY). Directed vectors
//   come from a table; random traffic is checked against a word-level model.
module tb_sram_access_ctrl;

    localparam int TO = 64;
    localparam logic [1:0] ST_FREE   = 2'b00;
    localparam logic [1:0] ST_BUSY   = 2'b01;
    localparam logic [1:0] ST_ACCESS = 2'b10;
    localparam logic [1:0] ST_ERROR  = 2'b11;

    localparam int M_OK     = 0;
    localparam int M_ERR_LO = 1;
    localparam int M_ERR_HI = 2;
    localparam int M_BUSY   = 3;

    typedef struct {
        logic        wr;
        logic [8:0]  idx;
        logic [63:0] wd;
        int          n;
        int          mode;
        logic        exp_err;
        int          exp_cyc;
        logic [63:0] exp_rd;
    } vec_t;

    logic clk;
    logic n_rst;
    int   errors;
    int   checks;

    logic [31:0] sram    [1024];
    logic [63:0] mdl_mem [512];
    logic [63:0] mdl_rdata;

    vec_t vecs [11];

    sram_access_ctrl_if bus ();

    sram_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_cycle(input int mode, input int n);
        if (mode == M_ERR_LO) return 2 + n;
        if (mode == M_BUSY)   return 1 + TO;
        return 4 + 2 * n;
    endfunction

    // Word-level reference: returns expected resp_err, updates model memory
    // and the last successfully read word.
    function automatic logic model_apply(input logic wr, input logic [8:0] idx,
                                         input logic [63:0] wd, input int mode);
        if (wr) begin
            if (mode == M_OK)     mdl_mem[idx] = wd;
            if (mode == M_ERR_HI) mdl_mem[idx][31:0] = wd[31:0];
        end else if (mode == M_OK) begin
            mdl_rdata = mdl_mem[idx];
        end
        return (mode != M_OK);
    endfunction

    // Starts just after a rising edge; returns just after the edge following
    // the response cycle.
    task automatic run_txn(input logic wr, input logic [8:0] idx, input logic [63:0] wd,
                           input int n, input int mode, input string tag,
                           output int resp_cyc, output logic resp_err,
                           output logic [63:0] resp_rd);
        int          c;
        int          st_start;
        int          nacc;
        logic        strobe;
        logic        prev_strobe;
        logic        both_bad;
        logic        unstable;
        logic [1:0]  st;
        logic [9:0]  acc_addr [4];
        logic        acc_wr   [4];
        logic [31:0] acc_wd   [4];
        int          expn;
        resp_cyc    = -1;
        resp_err    = 1'bx;
        resp_rd     = 'x;
        nacc        = 0;
        st_start    = 0;
        prev_strobe = 1'b0;
        both_bad    = 1'b0;
        unstable    = 1'b0;
        check({tag, " ready_before"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_idx    = idx;
        bus.req_wdata  = wd;
        bus.sram_state = ST_FREE;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = {$urandom, $urandom};
        bus.req_idx   = 9'($urandom);
        bus.req_write = 1'($urandom);
        c = 1;
        while (c < 200) begin
            strobe = bus.ren | bus.wen;
            if (bus.ren && bus.wen) both_bad = 1'b1;
            if (strobe && !prev_strobe) begin
                st_start = c;
                if (nacc < 4) begin
                    acc_addr[nacc] = bus.addr;
                    acc_wr[nacc]   = bus.wen;
                    acc_wd[nacc]   = bus.wdata;
                end
                nacc++;
            end else if (strobe && nacc <= 4) begin
                if (bus.addr !== acc_addr[nacc-1] || bus.wen !== acc_wr[nacc-1] ||
                    (bus.wen && bus.wdata !== acc_wd[nacc-1]))
                    unstable = 1'b1;
            end
            if (strobe) begin
                if (mode == M_BUSY)
                    st = ST_BUSY;
                else if (c - st_start == n)
                    st = ((mode == M_ERR_LO && nacc == 1) || (mode == M_ERR_HI && nacc == 2))
                         ? ST_ERROR : ST_ACCESS;
                else
                    st = ST_BUSY;
            end else begin
                st = 2'($urandom_range(0, 3));
            end
            bus.sram_state = st;
            bus.rdata = (st == ST_ACCESS && bus.ren) ? sram[bus.addr] : $urandom;
            if (st == ST_ACCESS && bus.wen) sram[bus.addr] = bus.wdata;
            prev_strobe = strobe;
            @(negedge clk);
            if (bus.resp_valid) begin
                resp_cyc = c;
                resp_err = bus.resp_err;
                resp_rd  = bus.resp_rdata;
            end
            @(posedge clk); #1;
            if (resp_cyc >= 0) break;
            c++;
        end
        bus.sram_state = ST_FREE;
        if (resp_cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL %s resp_wait: no resp_valid within %0d cycles", tag, c);
        end
        check({tag, " ready_after"}, 64'(bus.req_ready), 64'd1);
        check({tag, " resp_one_cycle"}, 64'(bus.resp_valid), 64'd0);
        check({tag, " ren_wen_excl"}, 64'(both_bad), 64'd0);
        check({tag, " strobe_stable"}, 64'(unstable), 64'd0);
        expn = (mode == M_OK || mode == M_ERR_HI) ? 2 : 1;
        check({tag, " n_access"}, 64'(nacc), 64'(expn));
        for (int i = 0; i < expn && i < nacc; i++) begin
            check({tag, " acc_addr"}, 64'(acc_addr[i]), 64'({idx, i[0]}));
            check({tag, " acc_kind"}, 64'(acc_wr[i]), 64'(wr));
            if (wr) check({tag, " acc_wdata"}, 64'(acc_wd[i]), 64'(i == 0 ? wd[31:0] : wd[63:32]));
        end
    endtask

    initial begin
        int          cyc;
        logic        rerr;
        logic [63:0] rrd;
        logic        eerr;
        int          seen;
        logic        wr;
        logic [8:0]  idx;
        logic [63:0] wd;
        int          n;
        int          mode;
        int          r;

        errors = 0;
        checks = 0;
        mdl_rdata = '0;
        for (int i = 0; i < 1024; i++) sram[i] = '0;
        for (int i = 0; i < 512; i++)  mdl_mem[i] = '0;

        //            wr    idx     wdata                   N  mode      err  cyc  resp_rdata
        vecs[0]  = '{1'b1, 9'h003, 64'h0101_0101_0101_0101, 2, M_OK,     1'b0, 8,  64'h0};
        vecs[1]  = '{1'b1, 9'h005, 64'hA00F_BC41_DEAD_BEEF, 1, M_OK,     1'b0, 6,  64'h0};
        vecs[2]  = '{1'b0, 9'h005, 64'h0,                   3, M_OK,     1'b0, 10, 64'hA00F_BC41_DEAD_BEEF};
        vecs[3]  = '{1'b1, 9'h1FF, 64'h0909_0909_0909_0909, 0, M_OK,     1'b0, 4,  64'hA00F_BC41_DEAD_BEEF};
        vecs[4]  = '{1'b0, 9'h1FF, 64'h0,                   2, M_OK,     1'b0, 8,  64'h0909_0909_0909_0909};
        vecs[5]  = '{1'b0, 9'h005, 64'h0,                   1, M_ERR_LO, 1'b1, 3,  64'h0909_0909_0909_0909};
        vecs[6]  = '{1'b0, 9'h003, 64'h0,                   1, M_OK,     1'b0, 6,  64'h0101_0101_0101_0101};
        vecs[7]  = '{1'b1, 9'h007, 64'h1234_5678_9ABC_DEF0, 1, M_BUSY,   1'b1, 65, 64'h0101_0101_0101_0101};
        vecs[8]  = '{1'b0, 9'h007, 64'h0,                   2, M_OK,     1'b0, 8,  64'h0};
        vecs[9]  = '{1'b1, 9'h009, 64'h5555_6666_7777_8888, 1, M_ERR_HI, 1'b1, 6,  64'h0};
        vecs[10] = '{1'b0, 9'h009, 64'h0,                   0, M_OK,     1'b0, 4,  64'h0000_0000_7777_8888};

        n_rst          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_idx    = '0;
        bus.req_wdata  = '0;
        bus.rdata      = '0;
        bus.sram_state = ST_FREE;
        #3;
        check("rst req_ready",  64'(bus.req_ready),  64'd0);
        check("rst resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst resp_err",   64'(bus.resp_err),   64'd0);
        check("rst resp_rdata", bus.resp_rdata,      64'd0);
        check("rst ren",        64'(bus.ren),        64'd0);
        check("rst wen",        64'(bus.wen),        64'd0);
        check("rst addr",       64'(bus.addr),       64'd0);
        check("rst wdata",      64'(bus.wdata),      64'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst req_ready", 64'(bus.req_ready), 64'd1);

        for (int v = 0; v < 11; v++) begin
            run_txn(vecs[v].wr, vecs[v].idx, vecs[v].wd, vecs[v].n, vecs[v].mode,
                    $sformatf("vec%0d", v), cyc, rerr, rrd);
            eerr = model_apply(vecs[v].wr, vecs[v].idx, vecs[v].wd, vecs[v].mode);
            check($sformatf("vec%0d resp_cycle", v), 64'(cyc), 64'(vecs[v].exp_cyc));
            check($sformatf("vec%0d resp_err", v), 64'(rerr), 64'(vecs[v].exp_err));
            check($sformatf("vec%0d resp_rdata", v), rrd, vecs[v].exp_rd);
        end

        // Reset while the high half of a write is on the bus (N=2).
        check("rstmid ready", 64'(bus.req_ready), 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_idx    = 9'h020;
        bus.req_wdata  = 64'hCAFE_F00D_1357_9BDF;
        bus.sram_state = ST_FREE;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            bus.sram_state = (c == 3) ? ST_ACCESS : ST_BUSY;
            if (c == 3 && bus.wen) sram[bus.addr] = bus.wdata;
            if (c < 5) begin
                @(posedge clk); #1;
            end
        end
        #1;
        check("rstmid hi_wen",  64'(bus.wen),  64'd1);
        check("rstmid hi_addr", 64'(bus.addr), 64'd65);
        n_rst = 1'b0;
        #1;
        check("rstmid ren",        64'(bus.ren),        64'd0);
        check("rstmid wen",        64'(bus.wen),        64'd0);
        check("rstmid addr",       64'(bus.addr),       64'd0);
        check("rstmid wdata",      64'(bus.wdata),      64'd0);
        check("rstmid resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rstmid req_ready",  64'(bus.req_ready),  64'd0);
        bus.sram_state = ST_FREE;
        @(posedge clk); #2;
        n_rst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
        end
        @(posedge clk); #1;
        check("rstmid no_spurious_resp", 64'(seen), 64'd0);
        check("rstmid ready_after",      64'(bus.req_ready), 64'd1);
        mdl_mem[9'h020][31:0] = 32'h1357_9BDF;
        mdl_rdata = '0;

        for (int t = 0; t < 40; t++) begin
            wr   = 1'($urandom);
            idx  = ($urandom_range(0, 3) == 0) ? 9'(511 - $urandom_range(0, 1))
                                               : 9'($urandom_range(0, 7));
            if (t % 8 == 7) idx = 9'h020;
            wd   = {$urandom, $urandom};
            n    = $urandom_range(0, 4);
            r    = $urandom_range(0, 19);
            mode = (r == 0) ? M_BUSY : (r <= 2) ? M_ERR_LO : (r <= 4) ? M_ERR_HI : M_OK;
            run_txn(wr, idx, wd, n, mode, $sformatf("rnd%0d", t), cyc, rerr, rrd);
            eerr = model_apply(wr, idx, wd, mode);
            check($sformatf("rnd%0d resp_cycle", t), 64'(cyc), 64'(exp_cycle(mode, n)));
            check($sformatf("rnd%0d resp_err", t), 64'(rerr), 64'(eerr));
            check($sformatf("rnd%0d resp_rdata", t), rrd, mdl_rdata);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Sits between the accelerator's AHB subordinate/register buffer and sram1024x32_wrapper.
- Turns 64-bit word read/write requests into two sequential 32-bit SRAM accesses: low half first, then high half.
- Follows the wrapper's sram_state handshake, reassembles 64-bit read data and reports errors and timeouts.
- Used for weight, input and bias staging and for weight loading into the compute array.

Parameters:
TIMEOUT_CYCLES, 64, max cycles a strobe may stay asserted without sram_state==ACCESS before the operation aborts with error
CNT_W, 7, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_write  input  1  1=write, 0=read
req_idx  input  9  64-bit word index
req_wdata  input  64  write data
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  64  read data, valid with resp_valid on reads
resp_err  output  1  completion was an error, qualified by resp_valid
addr  output  10  SRAM word address
ren  output  1  SRAM read strobe
wen  output  1  SRAM write strobe
wdata  output  32  SRAM write data
rdata  input  32  SRAM read data
sram_state  input  2  wrapper status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR

Behaviour:
- Clocking and reset: one clock, clk. Reset n_rst is asynchronous and active-low.
- Reset values: every output is 0, and the FSM is in IDLE.
- Reset asserted mid-operation: strobes drop immediately, no resp_valid is produced, and the captured request is discarded.
- FSM states: IDLE, LO_ACC, GAP, HI_ACC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture req_write, req_idx and req_wdata, then go to LO_ACC.
  - req_ready=0 in all other states. There is no queuing.
- LO_ACC:
  - addr={idx,1'b0}.
  - On writes: wen=1, wdata=wdata_q[31:0].
  - On reads: ren=1.
  - Strobe, addr and wdata are held stable for the whole state.
  - sram_state==ACCESS sampled: latch rdata into rdata_q[31:0] on reads, then go to GAP.
- GAP: one cycle with both strobes low, so the wrapper sees a distinct second access. Then go to HI_ACC.
- HI_ACC:
  - Same as LO_ACC, with addr={idx,1'b1}, wdata_q[63:32] and rdata_q[63:32].
  - On ACCESS, go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_err=err_q; then go to IDLE.
  - resp_rdata is registered and holds its value until the next read completes. Writes do not alter it.
  - resp_err holds its value until the next completion.
- Error during LO_ACC or HI_ACC (sram_state==ERROR sampled):
  - Strobes drop next cycle and err_q=1; go to RESP, skipping any remaining half.
  - A read that aborts in LO_ACC leaves resp_rdata unchanged.
  - sram_state ERROR/BUSY/ACCESS seen in IDLE, GAP or RESP is ignored.
- Timeout:
  - The counter clears on entry to LO_ACC/HI_ACC and increments each cycle without ACCESS.
  - At TIMEOUT_CYCLES it is treated exactly as ERROR.
- Precedence: ACCESS and ERROR cannot coexist (same 2-bit field). ERROR takes precedence over a timeout reached in the same cycle; the result is identical either way.
- ren and wen are never high together. Strobes are only ever high in LO_ACC/HI_ACC.
- Latency, with the wrapper returning ACCESS N cycles after the strobe rises:
  - Request accepted at cycle 0.
  - LO strobe at cycle 1 and ACCESS at cycle 1+N.
  - GAP at 2+N; HI strobe at 3+N; ACCESS at 3+2N.
  - resp_valid at 4+2N. Next req_ready at 5+2N.
- Address boundary: idx=511 maps to SRAM 1022/1023. There is no wrap and no idx range check.

Test Plan:
1. Reset, then write idx=0x003 with data 0x0101_0101_0101_0101, wrapper N=2 → wen at addr 6 then addr 7, wdata 0x01010101 both times. resp_valid at cycle 8, resp_err=0, and ren never high.
2. Write idx=0x005 with 0xA00F_BC41_DEAD_BEEF, then read idx=0x005 → SRAM sees 0xDEADBEEF at addr 10 and 0xA00FBC41 at addr 11. The read returns resp_rdata=0xA00F_BC41_DEAD_BEEF, resp_err=0.
3. Read idx=0x1FF after writing 0x0909_0909_0909_0909 → addr 1022 then 1023. resp_rdata=0x0909_0909_0909_0909; the GAP cycle has ren=wen=0.
4. Wrapper drives ERROR during the LO access of a read → no HI access is issued. resp_valid with resp_err=1; resp_rdata keeps its previous value. The next request completes normally with resp_err=0.
5. Wrapper holds BUSY forever → strobe stays high for 64 cycles, then drops. resp_valid=1 with resp_err=1, and req_ready returns to 1 the following cycle.
6. Assert n_rst during HI_ACC of a write → ren, wen, addr, wdata, resp_valid and req_ready are 0 asynchronously. After release, req_ready=1 and no spurious resp_valid occurs.
